neighbor_req_issuer: RTL and testbench
======================================

Name: neighbor_req_issuer

Overview:
Requester-side front end of the Neighbor SRAM subsystem. Accepts vertex jobs (start address, neighbor count, destination Edge PE), splits each into per-word neighbor read requests, and writes them into the Neighbor sync FIFO. Output valid is the FIFO write strobe, so the block gates itself on the FIFO's wfull. Sits between the vertex scheduler and the Neighbor SRAM integration block.

Parameters:
NUM_BANKS, 4, neighbor SRAM banks; power of two; BANK_W = log2(NUM_BANKS)
ROW_W, 10, per-bank row address width (bank depth 1024)
ADDR_W, ROW_W+BANK_W, global neighbor word address width
CNT_W, 8, neighbor count width
VID_W, 10, vertex ID width
PE_W, 2, Edge PE index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
job_valid  in  1  job offered
job_ready  out  1  job accepted when job_valid && job_ready
job_addr  in  ADDR_W  first neighbor word address
job_cnt  in  CNT_W  number of neighbor words; 0 is legal
job_vid  in  VID_W  source vertex ID
job_pe  in  PE_W  destination Edge PE
wfull  in  1  Neighbor FIFO full
req_valid  out  1  FIFO write strobe
req_bank  out  BANK_W  bank = addr[BANK_W-1:0]
req_row  out  ROW_W  row = addr[ADDR_W-1:BANK_W]
req_vid  out  VID_W  vertex ID of the current job
req_pe  out  PE_W  Edge PE of the current job
req_last  out  1  final request of the job
done_valid  out  1  one-cycle job-complete pulse
done_pe  out  PE_W  PE of the completed job

Behaviour:
- Reset (reset==0, async): state=IDLE; cur_addr, remaining, job regs and done regs cleared; all outputs 0 except job_ready=1 (IDLE). Any in-flight job is dropped with no partial request or done pulse. Outputs stay 0 until the first job is accepted after reset release.
- FSM states: IDLE and ISSUE.
- IDLE:
  - job_ready=1.
  - On accept with job_cnt>0: latch addr, cnt, vid and pe; go to ISSUE.
  - On accept with job_cnt==0: stay in IDLE; done_valid=1 the next cycle with done_pe=job_pe.
- ISSUE:
  - req_valid = !wfull (combinational gate). Field outputs come from registers.
  - When a push happens (req_valid==1): cur_addr increments mod 2^ADDR_W (wrap 0xFFF->0x000 at defaults; the bank field rolls into the row), and remaining decrements.
  - req_last = (remaining==1).
  - When wfull==1, req_valid=0 and all state holds. There is no timeout.
- Job completion and back-to-back jobs:
  - job_ready=1 in ISSUE only on the cycle the last request is pushed (remaining==1 && !wfull).
  - An accept on that cycle loads the new job and stays in ISSUE, or returns to IDLE if its cnt==0.
  - Otherwise the block returns to IDLE after the last push.
  - done_valid pulses the cycle after the last push, with that job's PE. The done registers are separate from the job registers, so a new job accepted on the same cycle does not corrupt done_pe.
  - Two jobs with cnt==0 on consecutive cycles produce two consecutive done pulses.
- Latency: job accepted at cycle N gives the first req_valid at N+1 (wfull low). A job of cnt=k with no stalls occupies cycles N+1..N+k, and done_valid is at N+k+1.
- Ordering: requests are strictly in address order; jobs are strictly in acceptance order.
- wfull rising in the same cycle as the intended last push: no push, last request retried, job_ready stays 0.

Optional Feature:
NEIGHBOR_REQ_PERF_EN: when defined, adds output perf_req_cnt (32b, +1 per push) and perf_stall_cnt (32b, +1 per ISSUE cycle with wfull==1). Both saturate at all-ones and clear on reset. When undefined, neither the ports nor the logic exist, and all other behaviour is identical.

Decomposition:
- Shared package: NUM_BANKS/ROW_W/CNT_W/VID_W/PE_W constants, a packed neighbor_job_t struct (addr, cnt, vid, pe), and a packed neighbor_req_t struct (valid, bank, row, vid, pe, last), so the request maps onto the Neighbor FIFO write data without re-packing.
- One sub-module: neighbor_addr_gen (cur_addr/remaining counter with load, step and last-detect), instantiated once.
- The FSM and done logic stay in the top.

Test Plan:
1. job addr=0x005, cnt=3, pe=2, wfull=0 -> pushes (bank1,row1),(bank2,row1),(bank3,row1) on N+1..N+3; req_last only on the third; done_valid at N+4 with done_pe=2.
2. job addr=0xFFE, cnt=4 -> (bank2,row0x3FF),(bank3,row0x3FF),(bank0,row0),(bank1,row0); wrap is correct.
3. cnt=5 with wfull held high for 3 cycles after the second push -> exactly 5 pushes, none during wfull, addresses contiguous, done_valid delayed by 3 cycles.
4. Back-to-back jobs A (cnt=2, pe=1) and B (cnt=1, pe=3) held valid -> B accepted on A's last-push cycle; pushes A0, A1, B0 with no bubble; done pe=1, then done pe=3 on consecutive cycles.
5. job cnt=0 pe=0 followed by job cnt=0 pe=1 -> no req_valid; two consecutive done pulses with pe 0 then 1.
6. reset asserted mid-job (after 2 of 6 pushes) -> outputs 0 immediately; after release, job_ready=1 and no stale requests or done pulse appear.

Source files
------------

// File: rtl/neighbor_req_issuer_pkg.sv
// -----------------------------------------------------------------------------
// neighbor_req_issuer_pkg
// Shared constants and types for the Neighbor SRAM requester front end.
//   - geometry constants (banks, row/address/count/vertex/PE widths)
//   - issuer_state_t : two-state issue FSM encoding
//   - neighbor_job_t : one vertex job as offered by the scheduler
//   - neighbor_req_t : one neighbor read request, laid out so it can be
//                      written straight into the Neighbor FIFO
//   - addr_bank/addr_row : split a global word address into bank and row
// -----------------------------------------------------------------------------
package neighbor_req_issuer_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int ROW_W     = 10;
  localparam int ADDR_W    = ROW_W + BANK_W;
  localparam int CNT_W     = 8;
  localparam int VID_W     = 10;
  localparam int PE_W      = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issuer_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [VID_W-1:0]  vid;
    logic [PE_W-1:0]   pe;
  } neighbor_job_t;

  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [VID_W-1:0]  vid;
    logic [PE_W-1:0]   pe;
    logic              last;
  } neighbor_req_t;

  // Low address bits select the bank so consecutive words interleave banks.
  function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
    return addr[BANK_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BANK_W];
  endfunction

endpackage

// File: rtl/neighbor_req_issuer_addr_gen.sv
// -----------------------------------------------------------------------------
// neighbor_addr_gen
// Word address / remaining-count walker for one vertex job.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            load a new job (wins over step)
//   load_addr/cnt   first word address and word count of the new job
//   step            one request was pushed: advance address, decrement count
//   cur_addr        address of the request currently offered
//   remaining       words still to be requested, including the current one
//   last            current request is the final one of the job
// -----------------------------------------------------------------------------
module neighbor_addr_gen
  import neighbor_req_issuer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  remaining,
  output logic              last
);

  logic [ADDR_W-1:0] cur_addr_reg;
  logic [CNT_W-1:0]  remaining_reg;

  // Address increments modulo 2^ADDR_W; the bank field carries into the row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
    end else if (load) begin
      cur_addr_reg  <= load_addr;
      remaining_reg <= load_cnt;
    end else if (step) begin
      cur_addr_reg  <= cur_addr_reg + ADDR_W'(1);
      remaining_reg <= remaining_reg - CNT_W'(1);
    end
  end

  assign cur_addr  = cur_addr_reg;
  assign remaining = remaining_reg;
  assign last      = (remaining_reg == CNT_W'(1));

endmodule

// File: rtl/neighbor_req_issuer.sv
// -----------------------------------------------------------------------------
// neighbor_req_issuer
// Requester front end of the Neighbor SRAM subsystem. Takes vertex jobs
// (first word address, word count, vertex ID, Edge PE), splits each into
// per-word read requests and writes them into the Neighbor FIFO. req_valid is
// the FIFO write strobe and is gated combinationally by wfull.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   job_valid/job_ready         job handshake
//   job_addr/cnt/vid/pe         job fields (cnt==0 is legal)
//   wfull                       Neighbor FIFO full
//   req_valid                   FIFO write strobe
//   req_bank/row/vid/pe/last    request fields
//   done_valid/done_pe          one-cycle job-complete pulse and its PE
// Optional (macro NEIGHBOR_REQ_PERF_EN):
//   perf_req_cnt                saturating count of pushes
//   perf_stall_cnt              saturating count of ISSUE cycles with wfull
// -----------------------------------------------------------------------------
module neighbor_req_issuer
  import neighbor_req_issuer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_addr,
  input  logic [CNT_W-1:0]  job_cnt,
  input  logic [VID_W-1:0]  job_vid,
  input  logic [PE_W-1:0]   job_pe,
  input  logic              wfull,
  output logic              req_valid,
  output logic [BANK_W-1:0] req_bank,
  output logic [ROW_W-1:0]  req_row,
  output logic [VID_W-1:0]  req_vid,
  output logic [PE_W-1:0]   req_pe,
  output logic              req_last,
  output logic              done_valid,
  output logic [PE_W-1:0]   done_pe
`ifdef NEIGHBOR_REQ_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  issuer_state_t state_reg, state_next;

  neighbor_job_t job_in;
  neighbor_req_t req_word;

  logic [VID_W-1:0]  vid_reg;
  logic [PE_W-1:0]   pe_reg;

  logic              done_valid_reg, done_valid_next;
  logic [PE_W-1:0]   done_pe_reg, done_pe_next;
  // Second done slot: holds a zero-count job's completion when it collides
  // with another completion in the same cycle, so no done pulse is lost.
  logic              pend_valid_reg, pend_valid_next;
  logic [PE_W-1:0]   pend_pe_reg, pend_pe_next;

  logic              load;
  logic              push;
  logic              ev_last;
  logic              ev_zero;
  logic              job_zero;

  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              last;

  assign job_in.addr = job_addr;
  assign job_in.cnt  = job_cnt;
  assign job_in.vid  = job_vid;
  assign job_in.pe   = job_pe;
  assign job_zero    = (job_in.cnt == '0);

  neighbor_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (job_in.addr),
    .load_cnt  (job_in.cnt),
    .step      (push),
    .cur_addr  (cur_addr),
    .remaining (remaining),
    .last      (last)
  );

  // ---------------------------------------------------------------------------
  // FSM and done arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    job_ready       = 1'b0;
    load            = 1'b0;
    push            = 1'b0;
    ev_last         = 1'b0;
    ev_zero         = 1'b0;
    done_valid_next = 1'b0;
    done_pe_next    = done_pe_reg;
    pend_valid_next = 1'b0;
    pend_pe_next    = pend_pe_reg;

    case (state_reg)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid && !job_zero) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        push = !wfull;
        // A new job may only be taken on the cycle the final word goes out,
        // which gives back-to-back jobs with no bubble.
        if (push && last) begin
          ev_last   = 1'b1;
          job_ready = 1'b1;
          if (job_valid && !job_zero) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ev_zero = job_valid && job_ready && job_zero;

    // Completions leave in acceptance order: pending slot first, then the
    // job finishing now, then a zero-count job accepted now.
    if (pend_valid_reg) begin
      done_valid_next = 1'b1;
      done_pe_next    = pend_pe_reg;
      pend_valid_next = ev_zero;
      pend_pe_next    = ev_zero ? job_in.pe : pend_pe_reg;
    end else if (ev_last) begin
      done_valid_next = 1'b1;
      done_pe_next    = pe_reg;
      pend_valid_next = ev_zero;
      pend_pe_next    = ev_zero ? job_in.pe : pend_pe_reg;
    end else if (ev_zero) begin
      done_valid_next = 1'b1;
      done_pe_next    = job_in.pe;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      vid_reg        <= '0;
      pe_reg         <= '0;
      done_valid_reg <= 1'b0;
      done_pe_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pend_pe_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      done_valid_reg <= done_valid_next;
      done_pe_reg    <= done_pe_next;
      pend_valid_reg <= pend_valid_next;
      pend_pe_reg    <= pend_pe_next;
      if (load) begin
        vid_reg <= job_in.vid;
        pe_reg  <= job_in.pe;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request word (FIFO write data layout)
  // ---------------------------------------------------------------------------
  assign req_word.valid = push;
  assign req_word.bank  = addr_bank(cur_addr);
  assign req_word.row   = addr_row(cur_addr);
  assign req_word.vid   = vid_reg;
  assign req_word.pe    = pe_reg;
  assign req_word.last  = (state_reg == ST_ISSUE) && last;

  assign req_valid  = req_word.valid;
  assign req_bank   = req_word.bank;
  assign req_row    = req_word.row;
  assign req_vid    = req_word.vid;
  assign req_pe     = req_word.pe;
  assign req_last   = req_word.last;
  assign done_valid = done_valid_reg;
  assign done_pe    = done_pe_reg;

`ifdef NEIGHBOR_REQ_PERF_EN
  logic [31:0] perf_req_cnt_reg;
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_cnt_reg   <= '0;
      perf_stall_cnt_reg <= '0;
    end else begin
      if (push && (perf_req_cnt_reg != '1)) begin
        perf_req_cnt_reg <= perf_req_cnt_reg + 32'd1;
      end
      if ((state_reg == ST_ISSUE) && wfull && (perf_stall_cnt_reg != '1)) begin
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_req_cnt   = perf_req_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_neighbor_req_issuer.sv
// -----------------------------------------------------------------------------
// tb_neighbor_req_issuer
// Scoreboard bench: every accepted job is expanded by a word-level reference
// model into expected requests and an expected done PE; a monitor pops and
// compares whenever the DUT presents req_valid or done_valid. Directed
// sequences additionally check cycle timing via per-cycle bitmaps.
// -----------------------------------------------------------------------------
module tb_neighbor_req_issuer;
  import neighbor_req_issuer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_addr;
  logic [CNT_W-1:0]  job_cnt;
  logic [VID_W-1:0]  job_vid;
  logic [PE_W-1:0]   job_pe;
  logic              wfull;
  logic              req_valid;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [VID_W-1:0]  req_vid;
  logic [PE_W-1:0]   req_pe;
  logic              req_last;
  logic              done_valid;
  logic [PE_W-1:0]   done_pe;

  always #5 clk = ~clk;

  neighbor_req_issuer dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_addr   (job_addr),
    .job_cnt    (job_cnt),
    .job_vid    (job_vid),
    .job_pe     (job_pe),
    .wfull      (wfull),
    .req_valid  (req_valid),
    .req_bank   (req_bank),
    .req_row    (req_row),
    .req_vid    (req_vid),
    .req_pe     (req_pe),
    .req_last   (req_last),
    .done_valid (done_valid),
    .done_pe    (done_pe)
  );

  typedef struct {
    int                jid;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [VID_W-1:0]  vid;
    logic [PE_W-1:0]   pe;
    logic              last;
  } exp_req_t;

  typedef struct {
    int              jid;
    logic [PE_W-1:0] pe;
  } exp_done_t;

  exp_req_t  exp_req_q[$];
  exp_done_t exp_done_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int job_id   = 0;

  logic [ADDR_W-1:0] sj_addr [8];
  logic [CNT_W-1:0]  sj_cnt  [8];
  logic [VID_W-1:0]  sj_vid  [8];
  logic [PE_W-1:0]   sj_pe   [8];

  logic [31:0]     seq_req_m;
  logic [31:0]     seq_done_m;
  int              seq_acc [8];
  logic [PE_W-1:0] seq_done_pe[$];
  bit              rand_wfull = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference model: a job of cnt words at addr reads addr, addr+1, ...
  // modulo the address space; bank = word mod NUM_BANKS, row = word div.
  function automatic void model_accept(input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] cnt,
                                       input logic [VID_W-1:0] vid, input logic [PE_W-1:0] pe);
    exp_req_t  e;
    exp_done_t d;
    for (int i = 0; i < int'(cnt); i++) begin
      int a;
      a      = (int'(addr) + i) % (1 << ADDR_W);
      e.jid  = job_id;
      e.bank = BANK_W'(a % NUM_BANKS);
      e.row  = ROW_W'(a / NUM_BANKS);
      e.vid  = vid;
      e.pe   = pe;
      e.last = (i == int'(cnt) - 1);
      exp_req_q.push_back(e);
    end
    d.jid = job_id;
    d.pe  = pe;
    exp_done_q.push_back(d);
    job_id++;
  endfunction

  task automatic monitor_loop();
    exp_req_t  e;
    exp_done_t d;
    forever begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        check("req_while_wfull", 64'(wfull), 64'd0);
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got bank=%0d row=0x%0h pe=%0d expected no request",
                   req_bank, req_row, req_pe);
        end else begin
          e = exp_req_q.pop_front();
          check("req_fields", 64'({req_bank, req_row, req_vid, req_pe, req_last}),
                64'({e.bank, e.row, e.vid, e.pe, e.last}));
        end
      end
      if (done_valid === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_unexpected: got done_pe=%0d expected no done", done_pe);
        end else begin
          d = exp_done_q.pop_front();
          check("done_pe", 64'(done_pe), 64'(d.pe));
          check("done_after_all_reqs",
                64'((exp_req_q.size() == 0) || (exp_req_q[0].jid > d.jid)), 64'd1);
        end
      end
    end
  endtask

  task automatic drive_job(input int ji, input int nj);
    if (ji < nj) begin
      job_valid = 1'b1;
      job_addr  = sj_addr[ji];
      job_cnt   = sj_cnt[ji];
      job_vid   = sj_vid[ji];
      job_pe    = sj_pe[ji];
    end else begin
      job_valid = 1'b0;
    end
  endtask

  task automatic set_wfull(input logic [31:0] wmask, input int c);
    if (rand_wfull) wfull = ($urandom_range(0, 3) == 0);
    else if (c < 32) wfull = wmask[c];
    else wfull = 1'b0;
  endtask

  // Presents jobs 0..nj-1 back to back (each held until accepted). Cycle 0 is
  // the cycle the first job is offered; bitmaps record req/done per cycle.
  task automatic run_seq(input int nj, input logic [31:0] wmask, input int window);
    int ji;
    ji         = 0;
    seq_req_m  = '0;
    seq_done_m = '0;
    seq_done_pe.delete();
    for (int k = 0; k < 8; k++) seq_acc[k] = -1;
    @(posedge clk);
    #1;
    drive_job(ji, nj);
    set_wfull(wmask, 0);
    for (int c = 0; c <= window; c++) begin
      @(negedge clk);
      if (job_valid && job_ready) begin
        seq_acc[ji] = c;
        model_accept(sj_addr[ji], sj_cnt[ji], sj_vid[ji], sj_pe[ji]);
        ji++;
      end
      if (c < 32) begin
        seq_req_m[c]  = req_valid;
        seq_done_m[c] = done_valid;
      end
      if (done_valid) seq_done_pe.push_back(done_pe);
      @(posedge clk);
      #1;
      drive_job(ji, nj);
      set_wfull(wmask, c + 1);
    end
    job_valid = 1'b0;
    wfull     = 1'b0;
    check("all_jobs_accepted", 64'(ji), 64'(nj));
  endtask

  task automatic set_job(input int i, input logic [ADDR_W-1:0] a, input int cnt,
                         input logic [VID_W-1:0] v, input logic [PE_W-1:0] p);
    sj_addr[i] = a;
    sj_cnt[i]  = CNT_W'(cnt);
    sj_vid[i]  = v;
    sj_pe[i]   = p;
  endtask

  task automatic check_done_pes(input string nm, input int n, input logic [PE_W-1:0] p0,
                                input logic [PE_W-1:0] p1, input logic [PE_W-1:0] p2);
    logic [PE_W-1:0] exp_pe [3];
    exp_pe[0] = p0;
    exp_pe[1] = p1;
    exp_pe[2] = p2;
    check({nm, "_done_count"}, 64'(seq_done_pe.size()), 64'(n));
    for (int i = 0; i < n && i < seq_done_pe.size(); i++)
      check({nm, "_done_pe_order"}, 64'(seq_done_pe[i]), 64'(exp_pe[i]));
  endtask

  initial begin
    reset     = 1'b0;
    job_valid = 1'b0;
    job_addr  = '0;
    job_cnt   = '0;
    job_vid   = '0;
    job_pe    = '0;
    wfull     = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_valid", 64'(req_valid), 64'd0);
    check("reset_done_valid", 64'(done_valid), 64'd0);
    check("reset_job_ready", 64'(job_ready), 64'd1);
    check("reset_req_fields", 64'({req_bank, req_row, req_vid, req_pe, req_last}), 64'd0);
    reset = 1'b1;

    // 1: basic three-word job
    set_job(0, 12'h005, 3, 10'h011, 2'd2);
    run_seq(1, 32'h0, 6);
    $display("t1 basic: acc=%0d req_m=0x%0h done_m=0x%0h", seq_acc[0], seq_req_m, seq_done_m);
    check("t1_accept_cycle", 64'(seq_acc[0]), 64'd0);
    check("t1_req_cycles", 64'(seq_req_m), 64'h0E);
    check("t1_done_cycle", 64'(seq_done_m), 64'h10);
    check_done_pes("t1", 1, 2'd2, 2'd0, 2'd0);

    // 2: address wrap 0xFFE -> 0x001
    set_job(0, 12'hFFE, 4, 10'h3A5, 2'd1);
    run_seq(1, 32'h0, 7);
    $display("t2 wrap: req_m=0x%0h done_m=0x%0h", seq_req_m, seq_done_m);
    check("t2_req_cycles", 64'(seq_req_m), 64'h1E);
    check("t2_done_cycle", 64'(seq_done_m), 64'h20);

    // 3: wfull high for 3 cycles after the second push
    set_job(0, 12'h100, 5, 10'h0F0, 2'd3);
    run_seq(1, 32'h38, 11);
    $display("t3 stall: req_m=0x%0h done_m=0x%0h", seq_req_m, seq_done_m);
    check("t3_req_cycles", 64'(seq_req_m), 64'h1C6);
    check("t3_done_cycle", 64'(seq_done_m), 64'h200);

    // 4: back-to-back A(cnt2,pe1) then B(cnt1,pe3)
    set_job(0, 12'h020, 2, 10'h001, 2'd1);
    set_job(1, 12'h7F3, 1, 10'h002, 2'd3);
    run_seq(2, 32'h0, 6);
    $display("t4 b2b: accA=%0d accB=%0d req_m=0x%0h done_m=0x%0h",
             seq_acc[0], seq_acc[1], seq_req_m, seq_done_m);
    check("t4_accept_b_cycle", 64'(seq_acc[1]), 64'd2);
    check("t4_req_cycles", 64'(seq_req_m), 64'h0E);
    check("t4_done_cycles", 64'(seq_done_m), 64'h18);
    check_done_pes("t4", 2, 2'd1, 2'd3, 2'd0);

    // 5: two zero-count jobs
    set_job(0, 12'h123, 0, 10'h010, 2'd0);
    set_job(1, 12'h456, 0, 10'h020, 2'd1);
    run_seq(2, 32'h0, 4);
    $display("t5 zero: req_m=0x%0h done_m=0x%0h", seq_req_m, seq_done_m);
    check("t5_req_cycles", 64'(seq_req_m), 64'h0);
    check("t5_done_cycles", 64'(seq_done_m), 64'h06);
    check_done_pes("t5", 2, 2'd0, 2'd1, 2'd0);

    // zero-count jobs taken on a last-push cycle and right after it
    set_job(0, 12'h300, 2, 10'h030, 2'd1);
    set_job(1, 12'h000, 0, 10'h031, 2'd2);
    set_job(2, 12'h000, 0, 10'h032, 2'd0);
    run_seq(3, 32'h0, 8);
    $display("t5b zero after last: done_m=0x%0h", seq_done_m);
    check_done_pes("t5b", 3, 2'd1, 2'd2, 2'd0);

    // 6: reset mid-job after 2 of 6 pushes
    set_job(0, 12'h200, 6, 10'h066, 2'd2);
    run_seq(1, 32'h0, 2);
    check("t6_req_before_reset", 64'(seq_req_m), 64'h06);
    reset = 1'b0;
    exp_req_q.delete();
    exp_done_q.delete();
    #1;
    $display("t6 reset: req_valid=%0b done_valid=%0b job_ready=%0b", req_valid, done_valid, job_ready);
    check("t6_reset_req_valid", 64'(req_valid), 64'd0);
    check("t6_reset_done_valid", 64'(done_valid), 64'd0);
    check("t6_reset_job_ready", 64'(job_ready), 64'd1);
    check("t6_reset_req_last", 64'(req_last), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (req_valid || done_valid) stale++;
      end
      check("t6_no_stale_outputs", 64'(stale), 64'd0);
      check("t6_job_ready_after", 64'(job_ready), 64'd1);
    end

    // random phase
    rand_wfull = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 8; i++) begin
        int cnt;
        cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 24)) : int'($urandom_range(0, 5));
        set_job(i, ADDR_W'($urandom), cnt, VID_W'($urandom), PE_W'($urandom));
      end
      run_seq(8, 32'h0, 300);
      for (int k = 0; k < 100 && (exp_req_q.size() != 0 || exp_done_q.size() != 0); k++)
        @(negedge clk);
      $display("rand batch %0d: jobs=%0d left_req=%0d left_done=%0d",
               b, job_id, exp_req_q.size(), exp_done_q.size());
      check("rand_reqs_drained", 64'(exp_req_q.size()), 64'd0);
      check("rand_dones_drained", 64'(exp_done_q.size()), 64'd0);
    end
    rand_wfull = 1'b0;

    repeat (4) @(posedge clk);
    check("final_req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("final_done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
